uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Downstream stage of the 8-channel flow output collector; consumes its `uart_en`/`uart_din` and produces `send_flag` plus the serial line.
- Serialises one BUSW-bit word as BUSW/8 consecutive 8N1 UART frames.
- A start is requested by any toggle of `uart_en`, not by its level.
- `send_flag` reports word completion so the collector can advance to its next channel.

Parameters:
- BUSW, 32, word width in bits; must be a multiple of 8 (8..64).
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate; BIT_CNT = CLK_FREQ/UART_BPS clock cycles per bit (integer division).

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- uart_en  in  1  send request; every 0->1 or 1->0 transition requests one word.
- uart_din  in  BUSW  word to send; sampled on the cycle a request is accepted.
- send_flag  out  1  one-cycle pulse when the last stop bit of a word completes.
- busy  out  1  high while a word is being transmitted.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Reset (async, any time, including mid-frame):
  - `uart_txd`=1, `send_flag`=0, `busy`=0.
  - `en_d`=0, pending=0, all counters=0.
  - An in-flight word is abandoned with no `send_flag`.
- Toggle detection:
  - `en_d` registers `uart_en` every cycle; toggle = `uart_en` XOR `en_d`.
  - Because `en_d` resets to 0, a `uart_en` held high at reset release counts as one toggle.
- FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: on toggle at edge T, latch `uart_din` into the shift register, set byte_idx=0 and `busy`=1, go to START. `uart_txd` is 0 from cycle T+1.
  - START: `uart_txd`=0 for BIT_CNT cycles, then DATA with bit_idx=0.
  - DATA: `uart_txd`=current byte bit[bit_idx], LSB first, BIT_CNT cycles per bit. After bit 7, go to STOP.
  - STOP: `uart_txd`=1 for BIT_CNT cycles.
    - If byte_idx < BUSW/8-1: increment byte_idx, go to START. No idle gap between bytes.
    - Otherwise: go to DONE.
  - DONE: lasts one cycle; `send_flag`=1, `busy`=0, `uart_txd`=1.
    - If pending=1: clear pending, latch current `uart_din`, go to START. `busy` returns to 1 the next cycle.
    - Otherwise: go to IDLE.
- Byte order: most-significant byte (bits BUSW-1:BUSW-8) first, least-significant byte last.
- Word timing:
  - Word duration = (BUSW/8)*10*BIT_CNT cycles.
  - `send_flag` is at T+(BUSW/8)*10*BIT_CNT+1.
- Baud counter: counts 0..BIT_CNT-1 and wraps. Bit advance occurs on the wrap cycle.
- Toggle while busy (START/DATA/STOP/DONE):
  - Sets pending=1; any number of toggles collapses into a single pending request.
  - `uart_din` is sampled only when the pending word starts, not when the toggle occurred.
  - A toggle in the DONE cycle itself also sets pending (or is consumed immediately if pending is already being serviced).
- `uart_din` changes during a transmission have no effect on the word in flight.
- Counter widths: sized by $clog2 of BIT_CNT, 8, and BUSW/8; no counter may overflow for any legal parameter set.

Test Plan:
1. Reset/idle: CLK_FREQ=8, UART_BPS=1 (BIT_CNT=8). Hold `sys_rst_n`=0 then release with `uart_en`=0 -> `uart_txd`=1, `busy`=0, `send_flag`=0 for 100 cycles.
2. Single word: `uart_din`=32'h12345678, toggle `uart_en` 0->1 at edge T.
   - `uart_txd` low T+1..T+8.
   - First byte 0x12 bits 0,1,0,0,1,0,0,0 at 8 cycles each, then stop.
   - Bytes 0x34, 0x56, 0x78 follow back-to-back.
   - `send_flag`=1 only at T+321; `busy` high T+1..T+320.
3. Alternating toggles as driven by the collector:
   - Toggle 1->0 with `uart_din`=32'hAABBCCDD after `send_flag` -> second word starts next cycle, bytes AA,BB,CC,DD.
   - Eight alternating toggles -> exactly eight `send_flag` pulses.
4. Pending collapse:
   - Three toggles during word 1, then `uart_din` changed to 32'h0000FFFF before word 1 ends.
   - Required: exactly one extra word, content 0x00,0x00,0xFF,0xFF, starting the cycle after the first `send_flag`; total two `send_flag` pulses.
5. Reset mid-frame: assert `sys_rst_n`=0 during DATA of byte 2 -> `uart_txd`=1 and `busy`=0 immediately (asynchronous), no `send_flag`. After release with `uart_en` stable, the line stays idle.
6. Parameter sweep: BUSW=8 and BUSW=64 with BIT_CNT=4.
   - Frame length 10*4 and 80*4 cycles respectively.
   - Byte order MSB-first.
   - `send_flag` at T+41 and T+321.

Source files
------------

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends one BUSW-bit word as BUSW/8 back-to-back 8N1 UART
// frames, most-significant byte first and LSB first within each byte.
// Each transmission is requested by a toggle of uart_en, not by its level.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   uart_en    request; every edge (0->1 or 1->0) asks for one word
//   uart_din   word to send, sampled when the request is accepted
//   send_flag  one-cycle pulse after the last stop bit of a word
//   busy       high while a word is on the line
//   uart_txd   serial output, idle high
module uart_word_tx #(
  parameter int BUSW     = 32,
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            uart_en,
  input  logic [BUSW-1:0] uart_din,
  output logic            send_flag,
  output logic            busy,
  output logic            uart_txd
);

  localparam int BIT_CNT = CLK_FREQ / UART_BPS;
  localparam int NBYTES  = BUSW / 8;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int BW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state;
  logic            r_en_d;
  logic            r_pend;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [BW-1:0]   r_byte;
  logic [BUSW-1:0] r_shift;

  logic       w_tog;
  logic       w_wrap;
  logic       w_last_byte;
  logic [7:0] w_cur_byte;

  assign w_tog       = uart_en ^ r_en_d;
  assign w_wrap      = (r_baud == CW'(BIT_CNT - 1));
  assign w_last_byte = (r_byte == BW'(NBYTES - 1));
  // The byte on the line always sits in the top 8 bits; the register is
  // shifted left by one byte after each stop bit.
  assign w_cur_byte  = r_shift[BUSW-1 -: 8];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_en_d  <= 1'b0;
      r_pend  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
    end else begin
      r_en_d <= uart_en;
      case (r_state)
        S_IDLE: begin
          if (w_tog) begin
            r_shift <= uart_din;
            r_byte  <= '0;
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tog) r_pend <= 1'b1;
          if (w_wrap) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tog) r_pend <= 1'b1;
          if (w_wrap) begin
            r_baud <= '0;
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          if (w_tog) r_pend <= 1'b1;
          if (w_wrap) begin
            r_baud <= '0;
            if (w_last_byte) begin
              r_state <= S_DONE;
            end else begin
              r_byte  <= r_byte + BW'(1);
              r_shift <= r_shift << 8;
              r_state <= S_START;
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DONE: begin
          // A request queued during the word, or arriving right now, starts
          // the next word immediately; multiple requests collapse into one.
          if (r_pend || w_tog) begin
            r_pend  <= 1'b0;
            r_shift <= uart_din;
            r_byte  <= '0;
            r_baud  <= '0;
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset forces the
  // idle line level without waiting for a clock.
  assign uart_txd  = (r_state == S_START) ? 1'b0 :
                     (r_state == S_DATA)  ? w_cur_byte[r_bit] : 1'b1;
  assign busy      = (r_state == S_START) || (r_state == S_DATA) ||
                     (r_state == S_STOP);
  assign send_flag = (r_state == S_DONE);

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

  localparam int NB = 4;
  localparam int BC = 8;
  localparam int D  = NB * 10 * BC;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_en = 1'b0;
  logic [31:0] uart_din = '0;
  logic        send_flag, busy, uart_txd;

  logic        en8 = 1'b0, en64 = 1'b0;
  logic [7:0]  din8 = '0;
  logic [63:0] din64 = '0;
  logic        f8, b8, t8, f64, b64, t64;

  int checks = 0;
  int failures = 0;
  int nprint = 0;
  int flags = 0;

  always #5 sys_clk = ~sys_clk;

  uart_word_tx #(.BUSW(32), .CLK_FREQ(8), .UART_BPS(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(uart_en),
    .uart_din(uart_din), .send_flag(send_flag), .busy(busy), .uart_txd(uart_txd));

  uart_word_tx #(.BUSW(8), .CLK_FREQ(4), .UART_BPS(1)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(en8),
    .uart_din(din8), .send_flag(f8), .busy(b8), .uart_txd(t8));

  uart_word_tx #(.BUSW(64), .CLK_FREQ(4), .UART_BPS(1)) dut64 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(en64),
    .uart_din(din64), .send_flag(f64), .busy(b64), .uart_txd(t64));

  // Expected line level at sample j (0-based) of a word: frame f, slot p.
  function automatic logic exp_bit(input logic [63:0] w, input int j, input int nb, input int bc);
    int f, p;
    f = j / (10 * bc);
    p = (j % (10 * bc)) / bc;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[(nb - 1 - f) * 8 + p - 1];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_j = sample index within current word (-1 idle,
  // D = completion cycle).
  int          m_j;
  logic        m_pend, m_end;
  logic [31:0] m_word;
  logic        m_tog;
  assign m_tog = uart_en ^ m_end;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_j <= -1; m_pend <= 1'b0; m_end <= 1'b0; m_word <= '0;
    end else begin
      m_end <= uart_en;
      if (m_j < 0) begin
        if (m_tog) begin m_j <= 0; m_word <= uart_din; end
      end else if (m_j < D) begin
        m_j <= m_j + 1;
        if (m_tog) m_pend <= 1'b1;
      end else if (m_pend || m_tog) begin
        m_j <= 0; m_word <= uart_din; m_pend <= 1'b0;
      end else begin
        m_j <= -1;
      end
    end
  end

  always @(negedge sys_clk) begin
    logic [2:0] e, a;
    if (m_j < 0)      e = 3'b100;
    else if (m_j < D) e = {exp_bit({32'h0, m_word}, m_j, NB, BC), 2'b10};
    else              e = 3'b101;
    a = {uart_txd, busy, send_flag};
    checks++;
    if (a !== e) begin
      failures++;
      if (nprint < 20) $display("FAIL model j=%0d act{txd,busy,flag}=%b exp=%b t=%0t", m_j, a, e, $time);
      nprint++;
    end
    if (send_flag) flags++;
  end

  function automatic logic txd_of(input int sel);
    return (sel == 0) ? uart_txd : (sel == 1) ? t8 : t64;
  endfunction
  function automatic logic flag_of(input int sel);
    return (sel == 0) ? send_flag : (sel == 1) ? f8 : f64;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy : (sel == 1) ? b8 : b64;
  endfunction

  // Receives one word: first posedge is the accepting edge T, then samples
  // each following cycle and decodes mid-bit like a UART receiver.
  task automatic capture(input int sel, output logic [63:0] word, output int flag_pos,
                         output int frame_err, output int busy_err);
    int nb, bc, dd;
    logic ln [0:700];
    nb = (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
    bc = (sel == 0) ? 8 : 4;
    dd = nb * 10 * bc;
    word = '0; flag_pos = -1; frame_err = 0; busy_err = 0;
    @(posedge sys_clk);
    for (int j = 0; j <= dd; j++) begin
      @(negedge sys_clk);
      ln[j] = txd_of(sel);
      if (flag_of(sel) && flag_pos < 0) flag_pos = j;
      if ((j < dd) && !busy_of(sel)) busy_err++;
      if ((j == dd) && busy_of(sel)) busy_err++;
    end
    for (int k = 0; k < nb; k++) begin
      int base;
      base = k * 10 * bc + bc / 2;
      if (ln[base] !== 1'b0) frame_err++;
      if (ln[base + 9 * bc] !== 1'b1) frame_err++;
      for (int b = 0; b < 8; b++) word[(nb - 1 - k) * 8 + b] = ln[base + (1 + b) * bc];
    end
  endtask

  typedef struct {
    logic [31:0] din;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [63:0] w;
    int fp, fe, be, f0;

    vt[0] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
    vt[1] = '{32'hAABBCCDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    vt[2] = '{32'h0000FFFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vt[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vt[4] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[5] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
    vt[6] = '{32'hA55A3CC3, 8'hA5, 8'h5A, 8'h3C, 8'hC3};
    vt[7] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset and idle
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (100) @(posedge sys_clk);
    #1;
    chk("idle_txd", 64'(uart_txd), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_flags", 64'(flags), 64'd0);

    // Table vectors, alternating toggles, collector-style back to back
    f0 = flags;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #2;
      uart_din = vt[i].din; uart_en = ~uart_en;
      capture(0, w, fp, fe, be);
      chk($sformatf("vec%0d_b0", i), w[31:24], 64'(vt[i].b0));
      chk($sformatf("vec%0d_b1", i), w[23:16], 64'(vt[i].b1));
      chk($sformatf("vec%0d_b2", i), w[15:8],  64'(vt[i].b2));
      chk($sformatf("vec%0d_b3", i), w[7:0],   64'(vt[i].b3));
      chk($sformatf("vec%0d_flagpos", i), 64'(fp), 64'(D));
      chk($sformatf("vec%0d_frame", i), 64'(fe), 64'd0);
      chk($sformatf("vec%0d_busy", i), 64'(be), 64'd0);
    end
    @(posedge sys_clk); #1;
    chk("vec_flag_count", 64'(flags - f0), 64'd8);

    // Pending collapse: three toggles during word 1, new data before it ends
    repeat (10) @(posedge sys_clk);
    f0 = flags;
    @(posedge sys_clk); #2;
    uart_din = 32'h11223344; uart_en = ~uart_en;
    fork
      capture(0, w, fp, fe, be);
      begin
        repeat (30) @(posedge sys_clk);
        #2 uart_en = ~uart_en;
        repeat (60) @(posedge sys_clk);
        #2 uart_en = ~uart_en;
        repeat (60) @(posedge sys_clk);
        #2 uart_en = ~uart_en;
        #1 uart_din = 32'h0000FFFF;
      end
    join
    chk("pend_w1", w, 64'h11223344);
    chk("pend_w1_flag", 64'(fp), 64'(D));
    capture(0, w, fp, fe, be);
    chk("pend_w2", w, 64'h0000FFFF);
    chk("pend_w2_flag", 64'(fp), 64'(D));
    chk("pend_w2_frame", 64'(fe + be), 64'd0);
    repeat (400) @(posedge sys_clk); #1;
    chk("pend_flag_count", 64'(flags - f0), 64'd2);

    // Random toggles and data changes, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 400)) @(posedge sys_clk);
      #2;
      if ($urandom_range(0, 3) != 0) uart_din = $urandom;
      uart_en = ~uart_en;
    end
    repeat (700) @(posedge sys_clk);

    // Asynchronous reset in the middle of byte 2
    @(posedge sys_clk); #2;
    uart_din = 32'hC3C3C3C3; uart_en = ~uart_en;
    repeat (80 + 8 + 24) @(posedge sys_clk);
    #1;
    chk("mid_busy_before", 64'(busy), 64'd1);
    f0 = flags;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_txd", 64'(uart_txd), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flag", 64'(send_flag), 64'd0);
    uart_en = 1'b0;
    repeat (5) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (100) @(posedge sys_clk); #1;
    chk("rst_no_flag", 64'(flags - f0), 64'd0);
    chk("rst_idle_txd", 64'(uart_txd), 64'd1);

    // Parameter sweep: BUSW=8 and BUSW=64 at 4 cycles per bit
    @(posedge sys_clk); #2;
    din8 = 8'hA5; en8 = ~en8;
    capture(1, w, fp, fe, be);
    chk("w8_data", w, 64'hA5);
    chk("w8_flag", 64'(fp), 64'd40);
    chk("w8_frame", 64'(fe + be), 64'd0);
    @(posedge sys_clk); #2;
    din64 = 64'h0123456789ABCDEF; en64 = ~en64;
    capture(2, w, fp, fe, be);
    chk("w64_data", w, 64'h0123456789ABCDEF);
    chk("w64_flag", 64'(fp), 64'd320);
    chk("w64_frame", 64'(fe + be), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
